fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle controller/datapath.
- Owns the PC register and drives instruction-memory requests, which may take several cycles.
- Holds the fetched instruction stable on `inst` until the core signals execution done.
- Consumes PCSel and the ALU result (branch/jump target) to select the next PC.

Parameters:
- nbit, 32: datapath/address width.
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- NOP_INST, 32'h0000_0013: value driven on `inst` when no valid instruction (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- PCSel  input  1  from controller: 0 = pc+4, 1 = jump/branch target.
- alu_out  input  nbit  ALU result, used as target when PCSel=1.
- exec_done  input  1  core has executed the current `inst` this cycle (retire strobe).
- imem_req  output  1  instruction-memory request, held until imem_valid.
- imem_addr  output  nbit  word-aligned fetch address.
- imem_rdata  input  nbit  instruction word from memory.
- imem_valid  input  1  imem_rdata valid; may assert in the same cycle as imem_req.
- inst  output  nbit  instruction to controller/decoder.
- inst_valid  output  1  `inst` holds a real fetched instruction.
- pc  output  nbit  address of `inst`.
- pc_plus4  output  nbit  pc+4, to writeback mux (WBSel=2).
- fault  output  1  sticky misaligned-target flag.
- instret  output  nbit  retired-instruction counter.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - state=BOOT, pc=RESET_PC, inst=NOP_INST.
  - inst_valid=0, imem_req=0, fault=0, instret=0.
- Reset mid-request drops the outstanding request. Any imem_valid arriving afterwards is ignored unless in FETCH/WAIT.
- FSM states: BOOT, FETCH, WAIT, ISSUE, FAULT.
  - BOOT: one cycle, no request; then FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
    - If imem_valid in the same cycle: latch imem_rdata into inst, inst_valid=1 next cycle, go to ISSUE (zero-wait path, 1-cycle fetch latency).
    - Otherwise go to WAIT.
  - WAIT: imem_req=1, imem_addr=pc held constant. On imem_valid: latch, go to ISSUE.
  - ISSUE: inst_valid=1, inst stable. imem_req=0. On exec_done:
    - Compute next = PCSel ? {alu_out[nbit-1:1],1'b0} : pc+4. Bit 0 is cleared per JALR semantics.
    - If next[1]=1: state=FAULT, fault=1, pc unchanged.
    - Otherwise pc=next, inst_valid=0, inst=NOP_INST, instret+=1, state=FETCH.
  - FAULT: terminal until reset. imem_req=0, inst_valid=0, inst=NOP_INST.
- exec_done outside ISSUE is ignored. PCSel and alu_out are sampled only on the exec_done cycle.
- imem_valid outside FETCH/WAIT is ignored.
- inst and pc are registered; they never change while inst_valid=1.
- pc_plus4 is combinational from pc, modulo 2^nbit (0xFFFF_FFFC+4 = 0).
- instret wraps modulo 2^nbit.
- Minimum issue rate: one instruction per 2 cycles (FETCH, then ISSUE) with a zero-wait memory.

Decomposition:
- Shared package riscv_pkg:
  - fetch_state_t enum (BOOT, FETCH, WAIT, ISSUE, FAULT).
  - NOP_INST constant.
  - The opcode/funct3/ALU-op enums already used by the controller, which it imports from here.
- One natural sub-module: pc_next_logic, a combinational next-PC mux with alignment check and misalignment output.

Test Plan:
- Reset → pc=0, inst=0x00000013, inst_valid=0. imem_req=0 in BOOT; imem_req=1 with imem_addr=0 on the following cycle.
- Zero-wait memory returning 0x00500093, 0x00100113, 0x002081B3, with exec_done pulsed each ISSUE and PCSel=0 → imem_addr sequence 0,4,8; instret=3.
- Memory with 3-cycle latency → imem_req held 3 cycles, addr constant, inst_valid rises only the cycle after imem_valid, inst unchanged before then.
- Branch taken: PCSel=1, alu_out=0x100 at exec_done → next imem_addr=0x100, pc_plus4=0x104.
- JALR target alu_out=0x201 → pc=0x200. Target 0x102 → fault=1, imem_req stays 0, pc stays at the branch address.
- rst_n=0 during WAIT, then a stale imem_valid during BOOT → ignored; state restarts and fetches from RESET_PC; fault and instret cleared.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the fetch stage and controller
//
// Purpose: fetch FSM state encoding, the canonical NOP instruction, and the
// opcode / funct3 / ALU-op encodings shared with the controller.
// Ports: none (package).

package riscv_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_t;

    typedef enum logic [2:0] {
        F3_ADD_SUB = 3'b000,
        F3_SLL     = 3'b001,
        F3_SLT     = 3'b010,
        F3_SLTU    = 3'b011,
        F3_XOR     = 3'b100,
        F3_SRL_SRA = 3'b101,
        F3_OR      = 3'b110,
        F3_AND     = 3'b111
    } funct3_t;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

endpackage

// File: rtl/pc_next_logic.sv
// rtl/pc_next_logic.sv - combinational next-PC mux with alignment check
//
// Purpose: selects pc+4 or the jump/branch target, clears target bit 0
// (JALR semantics) and flags a target that is not word aligned.
// Ports:
//   pc         in   current PC
//   PCSel      in   0 = pc+4, 1 = alu_out target
//   alu_out    in   ALU result used as target
//   pc_plus4   out  pc+4, modulo 2^nbit
//   next_pc    out  selected next PC
//   misaligned out  next_pc[1] set

module pc_next_logic #(
    parameter int nbit = 32
) (
    input  logic [nbit-1:0] pc,
    input  logic            PCSel,
    input  logic [nbit-1:0] alu_out,
    output logic [nbit-1:0] pc_plus4,
    output logic [nbit-1:0] next_pc,
    output logic            misaligned
);

    localparam logic [nbit-1:0] CLR_BIT0 = {{(nbit-1){1'b1}}, 1'b0};

    always_comb begin
        pc_plus4   = pc + nbit'(4);
        next_pc    = PCSel ? (alu_out & CLR_BIT0) : pc_plus4;
        // bit 0 is always cleared, so only bit 1 can make the target unaligned
        misaligned = next_pc[1];
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage owning the PC
//
// Purpose: issues instruction-memory requests, holds the fetched word on
// inst until the core retires it, then advances the PC.
// Ports:
//   clk, rst_n       in   clock, synchronous active-low reset
//   PCSel, alu_out   in   next-PC select and target, sampled on exec_done
//   exec_done        in   retire strobe for the current inst
//   imem_req/addr    out  memory request, held until imem_valid
//   imem_rdata/valid in   memory response (may arrive with the request)
//   inst, inst_valid out  instruction to decoder and its qualifier
//   pc, pc_plus4     out  address of inst and its successor
//   fault            out  sticky misaligned-target flag
//   instret          out  retired-instruction counter

module fetch_unit
    import riscv_pkg::fetch_state_t;
    import riscv_pkg::ST_BOOT;
    import riscv_pkg::ST_FETCH;
    import riscv_pkg::ST_WAIT;
    import riscv_pkg::ST_ISSUE;
    import riscv_pkg::ST_FAULT;
#(
    parameter int              nbit     = 32,
    parameter logic [nbit-1:0] RESET_PC = '0,
    parameter logic [nbit-1:0] NOP_INST = nbit'(riscv_pkg::NOP_INST)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCSel,
    input  logic [nbit-1:0] alu_out,
    input  logic            exec_done,
    output logic            imem_req,
    output logic [nbit-1:0] imem_addr,
    input  logic [nbit-1:0] imem_rdata,
    input  logic            imem_valid,
    output logic [nbit-1:0] inst,
    output logic            inst_valid,
    output logic [nbit-1:0] pc,
    output logic [nbit-1:0] pc_plus4,
    output logic            fault,
    output logic [nbit-1:0] instret
);

    fetch_state_t    state_q,      state_d;
    logic [nbit-1:0] pc_q,         pc_d;
    logic [nbit-1:0] inst_q,       inst_d;
    logic            inst_valid_q, inst_valid_d;
    logic            fault_q,      fault_d;
    logic [nbit-1:0] instret_q,    instret_d;

    logic [nbit-1:0] next_pc;
    logic            misaligned;

    pc_next_logic #(.nbit(nbit)) u_pc_next (
        .pc         (pc_q),
        .PCSel      (PCSel),
        .alu_out    (alu_out),
        .pc_plus4   (pc_plus4),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        fault_d      = fault_q;
        instret_d    = instret_q;
        imem_req     = 1'b0;
        imem_addr    = pc_q;

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH, ST_WAIT: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    inst_d       = imem_rdata;
                    inst_valid_d = 1'b1;
                    state_d      = ST_ISSUE;
                end else begin
                    state_d      = ST_WAIT;
                end
            end
            ST_ISSUE: begin
                if (exec_done) begin
                    inst_valid_d = 1'b0;
                    inst_d       = NOP_INST;
                    if (misaligned) begin
                        // PC stays on the offending branch so it can be inspected
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end else begin
                        pc_d      = next_pc;
                        instret_d = instret_q + nbit'(1);
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            fault_q      <= fault_d;
            instret_q    <= instret_d;
        end
    end

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign pc         = pc_q;
    assign fault      = fault_q;
    assign instret    = instret_q;

endmodule
